eviction_wb_param: RTL

Parametrised eviction write buffer between the cache (upstream Wishbone slave port) and physical memory (downstream Wishbone master port). It holds up to DEPTH dirty victim lines with byte masks, drains them to memory oldest-first in the background, and serves upstream reads that hit a buffered line. It generalises the fixed 4-line, 128-bit eviction buffer with configurable depth and width, byte-mask tracking, flush and retry handling.

---
 rtl/eviction_wb_param.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eviction_wb_param.sv
// eviction_wb_param: DEPTH-entry eviction write buffer between a cache Wishbone slave port and memory.
// Define EVICTION_WB_COALESCE_EN to merge upstream write hits into the buffered line.
module eviction_wb_param #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4,
    localparam int SEL_W = DATA_W / 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_dat_m,
    output logic [DATA_W-1:0] cpu_dat_s,
    input  logic [SEL_W-1:0]  cpu_sel,
    input  logic              cpu_stb,
    input  logic              cpu_cyc,
    input  logic              cpu_we,
    output logic              cpu_ack,
    output logic              cpu_rty,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_dat_m,
    input  logic [DATA_W-1:0] mem_dat_s,
    output logic [SEL_W-1:0]  mem_sel,
    output logic              mem_stb,
    output logic              mem_cyc,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic              mem_rty,
    input  logic              flush,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [2:0]        dbg_state
);
    // Handshakes: an upstream request is cpu_stb & cpu_cyc seen in IDLE and is held by the master
    // until a one-cycle cpu_ack or cpu_rty; downstream strobes stay stable until mem_ack or mem_rty.
    typedef enum logic [2:0] {IDLE, RESP, MEM_RD, RD_RESP, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [ADDR_W-1:0]   tag_q  [DEPTH];
    logic [ADDR_W-1:0]   tag_d  [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];
    logic [SEL_W-1:0]    mask_q [DEPTH];
    logic [SEL_W-1:0]    mask_d [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                cpu_ack_q, cpu_ack_d, cpu_rty_q, cpu_rty_d;
    logic [DATA_W-1:0]   cpu_dat_s_q, cpu_dat_s_d;
    logic                mem_stb_q, mem_stb_d, mem_cyc_q, mem_cyc_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0]   mem_dat_m_q, mem_dat_m_d;
    logic [SEL_W-1:0]    mem_sel_q, mem_sel_d;

    logic                req, full, hit, wr_rty, go_drain, alloc, free;
    logic [PTR_W-1:0]    hit_idx;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == cpu_adr)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign full = (count_q == CNT_W'(DEPTH));
    // Suppress re-sampling during the response cycle, while the master is still dropping stb.
    assign req  = cpu_stb && cpu_cyc && !cpu_ack_q && !cpu_rty_q;

    always_comb begin
        wr_rty = cpu_we && (full || flush);
`ifdef EVICTION_WB_COALESCE_EN
        if (state_q == DRAIN && hit && hit_idx == head_q) wr_rty = cpu_we;
`endif
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        mask_d      = mask_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cpu_ack_d   = 1'b0;
        cpu_rty_d   = 1'b0;
        cpu_dat_s_d = cpu_dat_s_q;
        mem_stb_d   = mem_stb_q;
        mem_cyc_d   = mem_cyc_q;
        mem_we_d    = mem_we_q;
        mem_adr_d   = mem_adr_q;
        mem_dat_m_d = mem_dat_m_q;
        mem_sel_d   = mem_sel_q;
        go_drain    = 1'b0;
        alloc       = 1'b0;
        free        = 1'b0;

        if (req && wr_rty && (state_q == IDLE || state_q == DRAIN)) cpu_rty_d = 1'b1;

        case (state_q)
            IDLE: begin
                if ((full || flush) && count_q != '0) begin
                    go_drain = 1'b1;
                end else if (req && !wr_rty) begin
                    if (cpu_we) begin
                        if (!hit) begin
                            alloc     = 1'b1;
                            cpu_ack_d = 1'b1;
                            state_d   = RESP;
                        end else begin
`ifdef EVICTION_WB_COALESCE_EN
                            for (int b = 0; b < SEL_W; b++) begin
                                if (cpu_sel[b]) data_d[hit_idx][8*b +: 8] = cpu_dat_m[8*b +: 8];
                            end
                            mask_d[hit_idx] = mask_q[hit_idx] | cpu_sel;
                            cpu_ack_d       = 1'b1;
                            state_d         = RESP;
`else
                            go_drain = 1'b1;
`endif
                        end
                    end else if (!hit) begin
                        state_d   = MEM_RD;
                        mem_stb_d = 1'b1;
                        mem_cyc_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_adr_d = cpu_adr;
                        mem_sel_d = '1;
                    end else if (&mask_q[hit_idx]) begin
                        cpu_dat_s_d = data_q[hit_idx];
                        cpu_ack_d   = 1'b1;
                        state_d     = RESP;
                    end else begin
                        go_drain = 1'b1;
                    end
                end else if (!req && count_q != '0) begin
                    go_drain = 1'b1;
                end
            end
            RESP, RD_RESP: state_d = IDLE;
            MEM_RD, DRAIN: begin
                if (mem_stb_q && mem_ack) begin
                    mem_stb_d = 1'b0;
                    mem_cyc_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == DRAIN) begin
                        free    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cpu_dat_s_d = mem_dat_s;
                        cpu_ack_d   = 1'b1;
                        state_d     = RD_RESP;
                    end
                end else if (mem_stb_q && mem_rty) begin
                    mem_stb_d = 1'b0;
                end else begin
                    mem_stb_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Drains always target the oldest entry; pending hits are re-evaluated afterwards.
        if (go_drain) begin
            state_d     = DRAIN;
            mem_stb_d   = 1'b1;
            mem_cyc_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_adr_d   = tag_q[head_q];
            mem_dat_m_d = data_q[head_q];
            mem_sel_d   = mask_q[head_q];
        end
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = cpu_adr;
            data_d[tail_q]  = cpu_dat_m;
            mask_d[tail_q]  = cpu_sel;
            tail_d          = tail_q + 1'b1;
        end
        if (free) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(free);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rty_q   <= 1'b0;
            cpu_dat_s_q <= '0;
            mem_stb_q   <= 1'b0;
            mem_cyc_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_dat_m_q <= '0;
            mem_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            mask_q      <= mask_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rty_q   <= cpu_rty_d;
            cpu_dat_s_q <= cpu_dat_s_d;
            mem_stb_q   <= mem_stb_d;
            mem_cyc_q   <= mem_cyc_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_dat_m_q <= mem_dat_m_d;
            mem_sel_q   <= mem_sel_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rty   = cpu_rty_q;
    assign cpu_dat_s = cpu_dat_s_q;
    assign mem_stb   = mem_stb_q;
    assign mem_cyc   = mem_cyc_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_dat_m = mem_dat_m_q;
    assign mem_sel   = mem_sel_q;
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign dbg_state = state_q;
endmodule
